pq_cmd_fifo: RTL

- Command front-end directly upstream of the heap priority queue; drives its `pq_if` device side (enq/deq/kvi, observes kvo/busy/full/empty).
- Buffers host commands (ENQ, DEQ, REPLACE) in a FIFO and issues them one at a time, only when the PQ is idle.
- Returns dequeued key/value pairs through a valid/ready response port, so hosts need not track PQ multi-cycle busy timing.

---
 rtl/pq_cmd_fifo_if.sv | 32 +++
 rtl/pq_cmd_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pq_cmd_fifo_if.sv
// Host command/response and PQ device-side signals of the pq_cmd_fifo front-end.
// slave is the front-end's view; master is the view of whoever drives the host and the PQ.
interface pq_cmd_fifo_if #(
    parameter int KVW = 32
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [KVW-1:0] cmd_kv;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [KVW-1:0] rsp_kv;
    logic           rsp_err;
    logic           drop_ovf;
    logic           pq_enq;
    logic           pq_deq;
    logic [KVW-1:0] pq_kvi;
    logic [KVW-1:0] pq_kvo;
    logic           pq_busy;
    logic           pq_full;
    logic           pq_empty;

    modport master (
        output cmd_valid, cmd_op, cmd_kv, rsp_ready, pq_kvo, pq_busy, pq_full, pq_empty,
        input  cmd_ready, rsp_valid, rsp_kv, rsp_err, drop_ovf, pq_enq, pq_deq, pq_kvi
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_kv, rsp_ready, pq_kvo, pq_busy, pq_full, pq_empty,
        output cmd_ready, rsp_valid, rsp_kv, rsp_err, drop_ovf, pq_enq, pq_deq, pq_kvi
    );
endinterface

// File: rtl/pq_cmd_fifo.sv
// Command FIFO in front of the heap priority queue: issues ENQ/DEQ/REPLACE one at a time
// when the PQ is idle and returns removed items on a valid/ready port. Define PQ_CMD_STATS_EN for counters.
module pq_cmd_fifo #(
    parameter int KVW   = 32,
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    pq_cmd_fifo_if.slave bus
`ifdef PQ_CMD_STATS_EN
    ,
    output logic [15:0]                n_enq,
    output logic [15:0]                n_deq,
    output logic [$clog2(DEPTH):0]     max_lvl
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ENQ = 2'b01;
    localparam logic [1:0] OP_DEQ = 2'b10;
    localparam logic [1:0] OP_REP = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t         state_q, state_d;

    logic [1:0]     op_mem [DEPTH];
    logic [KVW-1:0] kv_mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           rsp_valid_q, rsp_valid_d;
    logic [KVW-1:0] rsp_kv_q, rsp_kv_d;
    logic           rsp_err_q, rsp_err_d;
    logic           drop_ovf_q, drop_ovf_d;

    logic           cmd_ready;
    logic           push;
    logic           pop;
    logic [1:0]     head_op;
    logic [KVW-1:0] head_kv;

    logic           enq_c;
    logic           deq_c;
    logic [KVW-1:0] kvi_c;
    logic           rsp_load;
    logic [KVW-1:0] rsp_kv_new;
    logic           rsp_err_new;
    logic           drop_set;

    assign cmd_ready = (count_q < CW'(DEPTH));
    // NOPs are handshaken but never stored.
    assign push      = bus.cmd_valid && cmd_ready && (bus.cmd_op != OP_NOP);
    assign head_op   = op_mem[rd_ptr_q];
    assign head_kv   = kv_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q] <= bus.cmd_op;
            kv_mem[wr_ptr_q] <= bus.cmd_kv;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_kv_q    <= '0;
            rsp_err_q   <= 1'b0;
            drop_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_kv_q    <= rsp_kv_d;
            rsp_err_q   <= rsp_err_d;
            drop_ovf_q  <= drop_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        enq_c       = 1'b0;
        deq_c       = 1'b0;
        kvi_c       = '0;
        rsp_load    = 1'b0;
        rsp_kv_new  = '0;
        rsp_err_new = 1'b0;
        drop_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // An ENQ never produces a response, so it may issue past an unaccepted one.
                if ((count_q != '0) && !bus.pq_busy &&
                    ((head_op == OP_ENQ) || !rsp_valid_q || bus.rsp_ready)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pop   = 1'b1;
                kvi_c = head_kv;
                unique case (head_op)
                    OP_ENQ: begin
                        if (bus.pq_full) drop_set = 1'b1;
                        else             enq_c    = 1'b1;
                    end
                    OP_DEQ: begin
                        rsp_load = 1'b1;
                        if (bus.pq_empty) begin
                            rsp_err_new = 1'b1;
                        end else begin
                            deq_c      = 1'b1;
                            rsp_kv_new = bus.pq_kvo;
                        end
                    end
                    OP_REP: begin
                        rsp_load = 1'b1;
                        if (bus.pq_empty) begin
                            rsp_err_new = 1'b1;
                            if (bus.pq_full) drop_set = 1'b1;
                            else             enq_c    = 1'b1;
                        end else begin
                            enq_c      = 1'b1;
                            deq_c      = 1'b1;
                            rsp_kv_new = bus.pq_kvo;
                        end
                    end
                    default: ;
                endcase
                state_d = (enq_c || deq_c) ? SETTLE : IDLE;
            end
            SETTLE: begin
                // The PQ raises busy the cycle after a pulse, so this is never left early.
                if (!bus.pq_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_kv_d    = rsp_kv_q;
        rsp_err_d   = rsp_err_q;
        if (rsp_load) begin
            rsp_valid_d = 1'b1;
            rsp_kv_d    = rsp_kv_new;
            rsp_err_d   = rsp_err_new;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        drop_ovf_d = drop_ovf_q || drop_set;
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_kv    = rsp_kv_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.drop_ovf  = drop_ovf_q;
    assign bus.pq_enq    = enq_c;
    assign bus.pq_deq    = deq_c;
    assign bus.pq_kvi    = kvi_c;

`ifdef PQ_CMD_STATS_EN
    logic [15:0]   n_enq_q, n_enq_d;
    logic [15:0]   n_deq_q, n_deq_d;
    logic [CW-1:0] max_lvl_q, max_lvl_d;

    always_comb begin
        n_enq_d   = enq_c ? n_enq_q + 16'd1 : n_enq_q;
        n_deq_d   = deq_c ? n_deq_q + 16'd1 : n_deq_q;
        max_lvl_d = (count_d > max_lvl_q) ? count_d : max_lvl_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_enq_q   <= '0;
            n_deq_q   <= '0;
            max_lvl_q <= '0;
        end else begin
            n_enq_q   <= n_enq_d;
            n_deq_q   <= n_deq_d;
            max_lvl_q <= max_lvl_d;
        end
    end

    assign n_enq   = n_enq_q;
    assign n_deq   = n_deq_q;
    assign max_lvl = max_lvl_q;
`endif
endmodule
